seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Downstream display stage of the 4-digit BCD counter.
- Takes four 4-bit digit codes plus per-digit decimal points and time-multiplexes them onto the board's 8-bit segment bus and 4-bit digit-select bus.
- Features: frame-coherent input snapshot, leading-zero blanking, inter-digit dead time (anti-ghosting) and 16-step brightness control.
- All outputs are registered. SEG and DIGIT go directly to pins.

Parameters:
- CLK_HZ, 12000000, input clock frequency.
- DIGIT_HZ, 1000, dwell rate per digit. DIV = CLK_HZ/DIGIT_HZ cycles per digit slot.
- BLANK_CYCLES, 24, dead cycles at the start of each slot with all digits off. Must be ≥2. DIV must be > BLANK_CYCLES+16.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- units  in  4  digit 0 code (rightmost).
- tens  in  4  digit 1 code.
- hundreds  in  4  digit 2 code.
- thousands  in  4  digit 3 code (leftmost).
- dp  in  4  decimal point per digit; bit i = digit i, 1 = lit.
- blank_lz  in  1  1 = suppress leading zeros.
- brightness  in  4  0 = dimmest, 15 = full.
- SEG  out  8  active-low segments. SEG[0..6] = a..g, SEG[7] = dp.
- DIGIT  out  4  active-low digit enables. DIGIT[i] = digit i.
- frame_tick  out  1  one-cycle pulse when a new snapshot is taken.

Behaviour:
- Clock and reset:
  - One clock, CLK. Reset RST is synchronous, active-high.
  - While RST is high, at every clock: phase=0, idx=0, snapshot=0, SEG=8'hFF, DIGIT=4'hF, frame_tick=0.
  - Reset asserted mid-scan takes effect at the next edge. Outputs are dark on the cycle after it is sampled.
- Scan counters:
  - phase counts 0..DIV-1. At DIV-1 it wraps to 0 and idx increments 0→1→2→3→0.
- Snapshot:
  - On every cycle where phase==0 and idx==0, including the first cycle after reset release, all of units..thousands, dp, blank_lz and brightness are copied into the snapshot.
  - frame_tick is 1 on the following cycle.
  - Input changes at any other time have no visible effect until the next snapshot. Frame period = 4*DIV cycles.
- On-time:
  - on_time = ((snap_brightness+1)*(DIV-BLANK_CYCLES))>>4, integer truncation.
  - Slot active when BLANK_CYCLES ≤ phase < BLANK_CYCLES+on_time.
- Output registers (1-cycle latency from phase/idx):
  - DIGIT = ~(1<<idx) when active, else 4'hF.
  - SEG = {~dp_bit, ~segs} when active, else 8'hFF.
- Decode, codes 0-F, active-low SEG[6:0] values:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - In these values SEG[7] is shown as 1; dp is ORed in separately.
- Leading-zero blanking, only when snap_blank_lz=1:
  - thousands blank if it is 0.
  - hundreds blank if thousands is blank and hundreds is 0.
  - tens blank if hundreds is blank and tens is 0.
  - units never blanks.
  - A blank digit forces segments a-g off (SEG[6:0]=7F). Its dp still follows its dp bit. DIGIT timing is unchanged.
- No other state. No handshake. All widths are unsigned.

Test Plan:
All scenarios use CLK_HZ=1000, DIGIT_HZ=10 (DIV=100), BLANK_CYCLES=4.
1. RST held 10 cycles mid-scan, then released; thousands..units=1,2,3,4, brightness=15, blank_lz=0, dp=0 -> SEG=FF, DIGIT=F during reset and for cycles 1..4 after release; frame_tick pulses at cycle 1.
2. Same stimulus, 400 cycles -> DIGIT=1110 with SEG=99 for 96 consecutive cycles, then 1101/B0, 1011/A4, 0111/F9, 96 cycles each; frame_tick every 400 cycles.
3. brightness=0 -> each digit is low for exactly 6 cycles per 100-cycle slot. brightness=7 -> exactly 48 cycles.
4. blank_lz=1:
   - digits 0,0,0,7 -> slots 3,2,1 show SEG=FF and units shows F8.
   - digits 0,0,0,0 -> units shows C0.
   - digits 0,1,0,0 -> only thousands blank.
   - dp=4'b1000 with 0,0,0,7 -> thousands slot shows SEG=7F.
5. Change units from 4 to A at phase 50 of idx 0 -> the remainder of the frame still shows 99. After the next frame_tick, the units slot shows 88.
6. Codes A..F on all four digits with dp=4'b0101 -> SEG values 88/83/C6/A1/86/8E with bit 7 cleared on digits 0 and 2 only.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver: frame-coherent snapshot, leading-zero
// blanking, inter-digit dead time and 16-step PWM brightness.
module seg7_scan_driver #(
  parameter int CLK_HZ       = 12000000,
  parameter int DIGIT_HZ     = 1000,
  parameter int BLANK_CYCLES = 24
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] units,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  input  logic [3:0] thousands,
  input  logic [3:0] dp,
  input  logic       blank_lz,
  input  logic [3:0] brightness,
  output logic [7:0] SEG,
  output logic [3:0] DIGIT,
  output logic       frame_tick
);

  localparam int DIV  = CLK_HZ / DIGIT_HZ;
  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SPAN = DIV - BLANK_CYCLES;

  localparam logic [PW-1:0] PHASE_LAST = PW'(DIV - 1);
  localparam logic [31:0]   BLANK_U    = 32'(BLANK_CYCLES);
  localparam logic [31:0]   SPAN_U     = 32'(SPAN);

  // No handshake: inputs are free-running and only sampled at the frame start;
  // outputs are plain registered levels driven straight to the pins.

  logic [PW-1:0] phase;
  logic [1:0]    idx;

  logic [3:0] snap_units;
  logic [3:0] snap_tens;
  logic [3:0] snap_hundreds;
  logic [3:0] snap_thousands;
  logic [3:0] snap_dp;
  logic       snap_blank_lz;
  logic [3:0] snap_brightness;

  logic        frame_start;
  logic [31:0] on_time;
  logic [31:0] phase_ext;
  logic        active;

  logic       blank_th;
  logic       blank_hu;
  logic       blank_te;
  logic [3:0] sel_code;
  logic       sel_dp;
  logic       sel_blank;
  logic [6:0] sel_segs;

  function automatic logic [6:0] decode(input logic [3:0] code);
    decode = 7'h7F;
    case (code)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      4'hF: decode = 7'h0E;
      default: decode = 7'h7F;
    endcase
  endfunction

  assign frame_start = (phase == '0) && (idx == 2'd0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      phase <= '0;
      idx   <= 2'd0;
    end else if (phase == PHASE_LAST) begin
      phase <= '0;
      idx   <= idx + 2'd1;
    end else begin
      phase <= phase + PW'(1);
    end
  end

  // The snapshot is only consumed from phase BLANK_CYCLES onward, so loading it
  // on the same edge that decodes phase 0 never mixes old and new values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      snap_units      <= 4'd0;
      snap_tens       <= 4'd0;
      snap_hundreds   <= 4'd0;
      snap_thousands  <= 4'd0;
      snap_dp         <= 4'd0;
      snap_blank_lz   <= 1'b0;
      snap_brightness <= 4'd0;
    end else if (frame_start) begin
      snap_units      <= units;
      snap_tens       <= tens;
      snap_hundreds   <= hundreds;
      snap_thousands  <= thousands;
      snap_dp         <= dp;
      snap_blank_lz   <= blank_lz;
      snap_brightness <= brightness;
    end
  end

  always_comb begin
    on_time   = ((32'(snap_brightness) + 32'd1) * SPAN_U) >> 4;
    phase_ext = 32'(phase);
    active    = (phase_ext >= BLANK_U) && (phase_ext < (BLANK_U + on_time));
  end

  // Blanking cascades from the leftmost digit; units always shows.
  always_comb begin
    blank_th = snap_blank_lz && (snap_thousands == 4'd0);
    blank_hu = blank_th && (snap_hundreds == 4'd0);
    blank_te = blank_hu && (snap_tens == 4'd0);
  end

  always_comb begin
    sel_code  = snap_units;
    sel_dp    = snap_dp[0];
    sel_blank = 1'b0;
    case (idx)
      2'd0: begin
        sel_code  = snap_units;
        sel_dp    = snap_dp[0];
        sel_blank = 1'b0;
      end
      2'd1: begin
        sel_code  = snap_tens;
        sel_dp    = snap_dp[1];
        sel_blank = blank_te;
      end
      2'd2: begin
        sel_code  = snap_hundreds;
        sel_dp    = snap_dp[2];
        sel_blank = blank_hu;
      end
      default: begin
        sel_code  = snap_thousands;
        sel_dp    = snap_dp[3];
        sel_blank = blank_th;
      end
    endcase
    sel_segs = sel_blank ? 7'h7F : decode(sel_code);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      SEG        <= 8'hFF;
      DIGIT      <= 4'hF;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_start;
      if (active) begin
        DIGIT <= ~(4'b0001 << idx);
        SEG   <= {~sel_dp, sel_segs};
      end else begin
        DIGIT <= 4'hF;
        SEG   <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: expected lit runs {digit, seg, length} are queued
// per frame by the driver and matched by a run-detecting monitor.
module tb_seg7_scan_driver;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] units, tens, hundreds, thousands, dp, brightness;
  logic       blank_lz;
  logic [7:0] SEG;
  logic [3:0] DIGIT;
  logic       frame_tick;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic        mon_en = 1'b0;
  logic [19:0] exp_q[$];

  seg7_scan_driver #(
    .CLK_HZ(1000),
    .DIGIT_HZ(10),
    .BLANK_CYCLES(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .units(units),
    .tens(tens),
    .hundreds(hundreds),
    .thousands(thousands),
    .dp(dp),
    .blank_lz(blank_lz),
    .brightness(brightness),
    .SEG(SEG),
    .DIGIT(DIGIT),
    .frame_tick(frame_tick)
  );

  // clock / cycle counter
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [19:0] run(input logic [3:0] d, input logic [7:0] s, input int len);
    return {d, s, 8'(len)};
  endfunction

  // monitor: splits the output stream into runs of constant lit DIGIT/SEG
  logic [3:0]  cur_dig;
  logic [7:0]  cur_seg;
  int          run_len;
  int          last_tick;
  logic [19:0] mon_e;

  always @(negedge CLK) begin
    if (!mon_en) begin
      cur_dig   = 4'hF;
      cur_seg   = 8'hFF;
      run_len   = 0;
      last_tick = -1;
    end else begin
      if (DIGIT == 4'hF) chk("dark_seg", 32'(SEG), 32'h FF);
      if (DIGIT != cur_dig || SEG != cur_seg) begin
        if (cur_dig != 4'hF) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_run: got %0h, expected none", {cur_dig, cur_seg, 8'(run_len)});
          end else begin
            mon_e = exp_q.pop_front();
            chk("run", 32'({cur_dig, cur_seg, 8'(run_len)}), 32'(mon_e));
          end
        end
        cur_dig = DIGIT;
        cur_seg = SEG;
        run_len = 1;
      end else begin
        run_len++;
      end
      if (frame_tick) begin
        if (last_tick >= 0) chk("tick_period", 32'(cyc - last_tick), 32'd400);
        last_tick = cyc;
      end
    end
  end

  // driver tasks
  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!frame_tick && n < 600);
    if (!frame_tick) begin
      n_vec++;
      n_err++;
      $display("FAIL tick_timeout: got no frame_tick, expected one within 600 cycles");
    end
  endtask

  task automatic next_frame(input logic [3:0] th, input logic [3:0] hu, input logic [3:0] te,
                            input logic [3:0] un, input logic [3:0] d, input logic lz,
                            input logic [3:0] br, input int delay,
                            input logic [19:0] r0, input logic [19:0] r1,
                            input logic [19:0] r2, input logic [19:0] r3);
    repeat (delay) @(negedge CLK);
    thousands  = th;
    hundreds   = hu;
    tens       = te;
    units      = un;
    dp         = d;
    blank_lz   = lz;
    brightness = br;
    exp_q.push_back(r0);
    exp_q.push_back(r1);
    exp_q.push_back(r2);
    exp_q.push_back(r3);
    wait_tick();
  endtask

  initial begin
    thousands = 4'd1; hundreds = 4'd2; tens = 4'd3; units = 4'd4;
    dp = 4'b0000; blank_lz = 1'b0; brightness = 4'd15;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (150) @(negedge CLK);

    // reset mid-scan
    RST = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("rst_seg", 32'(SEG), 32'hFF);
      chk("rst_digit", 32'(DIGIT), 32'hF);
      chk("rst_tick", 32'(frame_tick), 32'd0);
    end
    exp_q.push_back(run(4'hE, 8'h99, 96));
    exp_q.push_back(run(4'hD, 8'hB0, 96));
    exp_q.push_back(run(4'hB, 8'hA4, 96));
    exp_q.push_back(run(4'h7, 8'hF9, 96));
    RST = 1'b0;
    @(negedge CLK);
    chk("rel_c1_tick", 32'(frame_tick), 32'd1);
    chk("rel_c1_seg", 32'(SEG), 32'hFF);
    chk("rel_c1_digit", 32'(DIGIT), 32'hF);
    mon_en = 1'b1;
    for (int c = 2; c <= 4; c++) begin
      @(negedge CLK);
      chk("rel_dark_tick", 32'(frame_tick), 32'd0);
      chk("rel_dark_seg", 32'(SEG), 32'hFF);
      chk("rel_dark_digit", 32'(DIGIT), 32'hF);
    end
    @(negedge CLK);
    chk("rel_c5_digit", 32'(DIGIT), 32'hE);
    chk("rel_c5_seg", 32'(SEG), 32'h99);

    // full brightness repeat, then brightness 0 and 7
    next_frame(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0, 4'd15, 0,
               run(4'hE, 8'h99, 96), run(4'hD, 8'hB0, 96), run(4'hB, 8'hA4, 96), run(4'h7, 8'hF9, 96));
    next_frame(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0, 4'd0, 0,
               run(4'hE, 8'h99, 6), run(4'hD, 8'hB0, 6), run(4'hB, 8'hA4, 6), run(4'h7, 8'hF9, 6));
    next_frame(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0, 4'd7, 0,
               run(4'hE, 8'h99, 48), run(4'hD, 8'hB0, 48), run(4'hB, 8'hA4, 48), run(4'h7, 8'hF9, 48));
    // leading-zero blanking
    next_frame(4'd0, 4'd0, 4'd0, 4'd7, 4'b0000, 1'b1, 4'd15, 0,
               run(4'hE, 8'hF8, 96), run(4'hD, 8'hFF, 96), run(4'hB, 8'hFF, 96), run(4'h7, 8'hFF, 96));
    next_frame(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b1, 4'd15, 0,
               run(4'hE, 8'hC0, 96), run(4'hD, 8'hFF, 96), run(4'hB, 8'hFF, 96), run(4'h7, 8'hFF, 96));
    next_frame(4'd0, 4'd1, 4'd0, 4'd0, 4'b0000, 1'b1, 4'd15, 0,
               run(4'hE, 8'hC0, 96), run(4'hD, 8'hC0, 96), run(4'hB, 8'hF9, 96), run(4'h7, 8'hFF, 96));
    next_frame(4'd0, 4'd0, 4'd0, 4'd7, 4'b1000, 1'b1, 4'd15, 0,
               run(4'hE, 8'hF8, 96), run(4'hD, 8'hFF, 96), run(4'hB, 8'hFF, 96), run(4'h7, 8'h7F, 96));
    // snapshot coherence: units changes at phase 50 of idx 0
    next_frame(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0, 4'd15, 0,
               run(4'hE, 8'h99, 96), run(4'hD, 8'hB0, 96), run(4'hB, 8'hA4, 96), run(4'h7, 8'hF9, 96));
    next_frame(4'd1, 4'd2, 4'd3, 4'hA, 4'b0000, 1'b0, 4'd15, 49,
               run(4'hE, 8'h88, 96), run(4'hD, 8'hB0, 96), run(4'hB, 8'hA4, 96), run(4'h7, 8'hF9, 96));
    // hex codes with decimal points on digits 0 and 2
    next_frame(4'hD, 4'hC, 4'hB, 4'hA, 4'b0101, 1'b0, 4'd15, 0,
               run(4'hE, 8'h08, 96), run(4'hD, 8'h83, 96), run(4'hB, 8'h46, 96), run(4'h7, 8'hA1, 96));
    next_frame(4'hF, 4'hE, 4'hD, 4'hC, 4'b0101, 1'b0, 4'd15, 0,
               run(4'hE, 8'h46, 96), run(4'hD, 8'hA1, 96), run(4'hB, 8'h06, 96), run(4'h7, 8'h8E, 96));
    next_frame(4'd5, 4'd6, 4'd8, 4'd9, 4'b0000, 1'b0, 4'd15, 0,
               run(4'hE, 8'h90, 96), run(4'hD, 8'h80, 96), run(4'hB, 8'h82, 96), run(4'h7, 8'h92, 96));

    wait_tick();
    repeat (2) @(negedge CLK);
    mon_en = 1'b0;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
